apb_master_nslave: RTL and testbench
====================================

// Module: apb_master_nslave
// PURPOSE
// - Parametrised APB master bridge: the next generation of the two-slave bridge. Drives NSLV slaves.
// - Accepts one read/write command per handshake on the user side and runs the APB SETUP/ACCESS phases.
// - Handles wait states (PREADY) and reports errors from PSLVERR, address decode miss or access timeout.
// - Sits between the testbench/driver command port (apb_if signal set) and the slave fabric.
// PARAMETERS
// - AW       32  address width; upper SW=$clog2(NSLV) bits select the slave (SW=1 when NSLV=1)
// - DW       32  data width
// - NSLV     2   number of slaves, 1..16
// - TIMEOUT  16  max ACCESS cycles waiting for PREADY; 0 = no timeout
// PORTS
// - pclk              in   1        APB clock
// - presetn           in   1        reset, synchronous, active-low
// - transfer          in   1        command valid
// - cmd_ready         out  1        command accepted on a cycle where transfer && cmd_ready
// - read_write        in   1        1 = read, 0 = write
// - apb_write_paddr   in   AW       write address
// - apb_write_data    in   DW       write data
// - apb_read_paddr    in   AW       read address
// - apb_read_data_out out  DW       read data, valid with rsp_valid on reads
// - rsp_valid         out  1        one-cycle completion pulse
// - rsp_err           out  1        error flag qualified by rsp_valid
// - paddr             out  AW       APB address
// - psel              out  NSLV     one-hot slave select
// - penable           out  1        APB enable
// - pwrite            out  1        APB direction
// - pwdata            out  DW       APB write data
// - prdata            in   NSLV*DW  slave read data, slave i at [i*DW +: DW]
// - pready            in   NSLV     per-slave ready
// - pslverr           in   NSLV     per-slave error
// BEHAVIOUR
// - Reset, sampled at posedge pclk while presetn=0:
//   - state=IDLE; all outputs 0; cmd_ready=0 during reset, 1 in the first cycle after release.
//   - Reset mid-transfer abandons it: no rsp_valid, psel/penable drop the next cycle.
// - FSM: IDLE -> SETUP -> ACCESS -> IDLE, plus DERR for decode errors.
// - IDLE: cmd_ready=1.
//   - On accept: latch read_write and the selected address (apb_read_paddr if read, else apb_write_paddr) and apb_write_data.
//   - idx = addr[AW-1 -: SW]. If idx<NSLV, go to SETUP; else go to DERR.
// - SETUP: psel[idx]=1, penable=0, paddr/pwrite/pwdata from the latched command. Always go to ACCESS.
// - ACCESS: psel[idx]=1, penable=1. APB signals are held stable. Wait counter increments per cycle.
//   - pready[idx]=1: go to IDLE; next cycle rsp_valid=1, rsp_err=pslverr[idx].
//     - Read without error: apb_read_data_out = prdata slice idx.
//     - Read with pslverr: apb_read_data_out = 0.
//   - TIMEOUT!=0 and counter==TIMEOUT-1 without pready: go to IDLE.
//     - psel/penable drop; next cycle rsp_valid=1, rsp_err=1, read data = 0.
// - DERR: no psel asserted. Return to IDLE with rsp_valid=1, rsp_err=1 the next cycle.
// - cmd_ready=0 in SETUP, ACCESS and DERR. Only one command is outstanding at a time.
// - Latency (zero-wait): accept at cycle n, SETUP n+1, ACCESS n+2, rsp_valid n+3.
//   - cmd_ready=1 in cycle n+3, so a back-to-back accept is allowed.
// - Each wait state adds one cycle.
// - apb_read_data_out holds its value between reads; writes do not change it.
// - rsp_err is 0 whenever rsp_valid=0.
// - psel, penable and pwrite are 0 in IDLE; paddr/pwdata keep their last values.
// - Counter width is $clog2(TIMEOUT+1); it clears on entry to SETUP.
// TESTING
// - Reset: presetn=0 for 3 cycles -> psel=0, penable=0, rsp_valid=0, cmd_ready=0; cmd_ready=1 in the first cycle after release.
// - Write, NSLV=2: addr 0x0000_0010, data 0xA5A5_5A5A, pready=1.
//   -> psel=2'b01 SETUP, penable ACCESS, rsp_valid 3 cycles after accept, rsp_err=0.
// - Read from slave1: addr 0x8000_0004, prdata1=0x1234_5678, 2 wait states.
//   -> ACCESS lasts 3 cycles; rsp_valid with data 0x1234_5678.
// - Error paths:
//   - pslverr=1 with pready on a read -> rsp_err=1, data 0.
//   - NSLV=3, addr 0xC000_0000 -> DERR, no psel, rsp_err=1.
// - Timeout: TIMEOUT=4, pready held 0 -> exactly 4 ACCESS cycles, then psel drops, rsp_valid=1, rsp_err=1.
// - Back-to-back and reset abort:
//   - transfer held high for 2 commands -> second accepted in the rsp_valid cycle, no idle gap.
//   - presetn=0 during ACCESS -> no rsp_valid, psel=0 the next cycle.

Source files
------------

// File: rtl/apb_master_nslave.sv
// APB master bridge for NSLV slaves: one command at a time,
// with wait states, slave error, decode miss and access timeout.
module apb_master_nslave #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NSLV    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 transfer,
  output logic                 cmd_ready,
  input  logic                 read_write,
  input  logic [AW-1:0]        apb_write_paddr,
  input  logic [DW-1:0]        apb_write_data,
  input  logic [AW-1:0]        apb_read_paddr,
  output logic [DW-1:0]        apb_read_data_out,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [AW-1:0]        paddr,
  output logic [NSLV-1:0]      psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [DW-1:0]        pwdata,
  input  logic [NSLV*DW-1:0]   prdata,
  input  logic [NSLV-1:0]      pready,
  input  logic [NSLV-1:0]      pslverr
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DERR
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic          r_rd;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_rdata;
  logic          r_rsp_valid;
  logic          r_rsp_err;

  logic          w_accept;
  logic [AW-1:0] w_addr;
  logic [SW-1:0] w_idx;
  logic          w_hit;
  logic          w_act;
  logic          w_rdy;
  logic          w_err;
  logic [DW-1:0] w_slice;
  logic          w_tmo;
  logic          w_rsp_set;
  logic          w_rsp_err;
  logic          w_rd_upd;
  logic [DW-1:0] w_rd_val;

  assign cmd_ready = presetn && (r_state == IDLE);
  assign w_accept  = transfer && cmd_ready;
  assign w_addr    = read_write ? apb_read_paddr
                                : apb_write_paddr;
  assign w_idx     = w_addr[AW-1 -: SW];
  assign w_hit     = {{(32-SW){1'b0}}, w_idx} < NSLV[31:0];
  assign w_act     = (r_state == SETUP) ||
                     (r_state == ACCESS);

  // Per-slave mux; only a decoded (in-range) index reaches SETUP.
  always_comb begin
    w_rdy   = 1'b0;
    w_err   = 1'b0;
    w_slice = '0;
    psel    = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_idx == SW'(i)) begin
        w_rdy   = pready[i];
        w_err   = pslverr[i];
        w_slice = prdata[i*DW +: DW];
        psel[i] = w_act;
      end
    end
  end

  if (TIMEOUT > 0) begin : g_tmo
    assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));
  end else begin : g_ntmo
    assign w_tmo = 1'b0;
  end

  always_comb begin
    w_next    = r_state;
    w_rsp_set = 1'b0;
    w_rsp_err = 1'b0;
    w_rd_upd  = 1'b0;
    w_rd_val  = '0;
    unique case (r_state)
      IDLE: begin
        if (w_accept)
          w_next = w_hit ? SETUP : DERR;
      end
      SETUP: begin
        w_next = ACCESS;
      end
      ACCESS: begin
        if (w_rdy) begin
          w_next    = IDLE;
          w_rsp_set = 1'b1;
          w_rsp_err = w_err;
          w_rd_upd  = r_rd;
          w_rd_val  = w_err ? '0 : w_slice;
        end else if (w_tmo) begin
          w_next    = IDLE;
          w_rsp_set = 1'b1;
          w_rsp_err = 1'b1;
          w_rd_upd  = r_rd;
        end
      end
      DERR: begin
        w_next    = IDLE;
        w_rsp_set = 1'b1;
        w_rsp_err = 1'b1;
        w_rd_upd  = r_rd;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_rd        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rd    <= read_write;
        r_addr  <= w_addr;
        r_wdata <= apb_write_data;
        r_idx   <= w_idx;
      end
      if (w_next == SETUP)
        r_cnt <= '0;
      else if (r_state == ACCESS)
        r_cnt <= r_cnt + 1'b1;
      if (w_rd_upd)
        r_rdata <= w_rd_val;
      r_rsp_valid <= w_rsp_set;
      r_rsp_err   <= w_rsp_err;
    end
  end

  assign paddr             = r_addr;
  assign pwdata            = r_wdata;
  assign penable           = (r_state == ACCESS);
  assign pwrite            = w_act && !r_rd;
  assign apb_read_data_out = r_rdata;
  assign rsp_valid         = r_rsp_valid;
  assign rsp_err           = r_rsp_err;

endmodule

// File: tb/tb_apb_master_nslave.sv
// Bench for apb_master_nslave: two-slave instance with a short
// timeout, three-slave instance for decode miss and no-timeout waits.
module tb_apb_master_nslave;

  typedef struct {
    logic        err;
    logic        rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        tr_a = 1'b0;
  logic        tr_b = 1'b0;
  logic        read_write = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] rd_addr = '0;
  logic [31:0] wr_data = '0;

  logic        rdy_a, rdy_b;
  logic [31:0] rdata_a, rdata_b;
  logic        vld_a, vld_b, err_a, err_b;
  logic [31:0] paddr_a, paddr_b, pwdata_a, pwdata_b;
  logic [1:0]  psel_a;
  logic [2:0]  psel_b;
  logic        pen_a, pen_b, pwr_a, pwr_b;
  logic [63:0] prdata_a;
  logic [95:0] prdata_b;
  logic [1:0]  pready_a, pslverr_a;
  logic [2:0]  pready_b, pslverr_b;

  int   cfg_wait = 0;
  logic cfg_hang = 1'b0;
  logic cfg_err  = 1'b0;
  int   wc_a = 0;
  int   wc_b = 0;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [31:0] exp_rd_a = '0;
  logic [31:0] exp_rd_b = '0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_master_nslave #(.AW(32), .DW(32), .NSLV(2), .TIMEOUT(4)) u_a (
    .pclk(pclk), .presetn(presetn), .transfer(tr_a),
    .cmd_ready(rdy_a), .read_write(read_write),
    .apb_write_paddr(wr_addr), .apb_write_data(wr_data),
    .apb_read_paddr(rd_addr), .apb_read_data_out(rdata_a),
    .rsp_valid(vld_a), .rsp_err(err_a),
    .paddr(paddr_a), .psel(psel_a), .penable(pen_a),
    .pwrite(pwr_a), .pwdata(pwdata_a), .prdata(prdata_a),
    .pready(pready_a), .pslverr(pslverr_a)
  );

  apb_master_nslave #(.AW(32), .DW(32), .NSLV(3), .TIMEOUT(0)) u_b (
    .pclk(pclk), .presetn(presetn), .transfer(tr_b),
    .cmd_ready(rdy_b), .read_write(read_write),
    .apb_write_paddr(wr_addr), .apb_write_data(wr_data),
    .apb_read_paddr(rd_addr), .apb_read_data_out(rdata_b),
    .rsp_valid(vld_b), .rsp_err(err_b),
    .paddr(paddr_b), .psel(psel_b), .penable(pen_b),
    .pwrite(pwr_b), .pwdata(pwdata_b), .prdata(prdata_b),
    .pready(pready_b), .pslverr(pslverr_b)
  );

  // Slave models: ready after cfg_wait ACCESS cycles unless hung.
  assign prdata_a  = {32'h1234_5678, 32'h0BAD_F00D};
  assign prdata_b  = {32'h55AA_33CC, 32'h2222_2222, 32'h1111_1111};
  assign pready_a  = psel_a &
    {2{pen_a && !cfg_hang && wc_a == cfg_wait}};
  assign pready_b  = psel_b &
    {3{pen_b && !cfg_hang && wc_b == cfg_wait}};
  assign pslverr_a = psel_a & {2{cfg_err}};
  assign pslverr_b = psel_b & {3{cfg_err}};

  always @(posedge pclk) begin
    wc_a <= (pen_a && !(|pready_a)) ? wc_a + 1 : 0;
    wc_b <= (pen_b && !(|pready_b)) ? wc_b + 1 : 0;
  end

  function automatic void cmp(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitors: pop and compare on every response pulse.
  always @(negedge pclk) begin
    exp_t e;
    if (!presetn) exp_rd_a = '0;
    if (vld_a) begin
      if (qa.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL a_unexpected_rsp: got rsp_valid at cycle %0d", cyc);
      end else begin
        e = qa.pop_front();
        if (e.rd) exp_rd_a = e.data;
        cmp("a_rsp_err", {31'd0, err_a}, {31'd0, e.err});
        cmp("a_rsp_cycle", cyc, e.cyc);
        cmp("a_rdata", rdata_a, exp_rd_a);
        cmp("a_bus_idle", {29'd0, pen_a, psel_a}, 32'd0);
      end
    end else if (err_a) begin
      nerr++;
      $display("FAIL a_err_without_valid: got 1 expected 0");
    end
  end

  always @(negedge pclk) begin
    exp_t e;
    if (!presetn) exp_rd_b = '0;
    if (vld_b) begin
      if (qb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL b_unexpected_rsp: got rsp_valid at cycle %0d", cyc);
      end else begin
        e = qb.pop_front();
        if (e.rd) exp_rd_b = e.data;
        cmp("b_rsp_err", {31'd0, err_b}, {31'd0, e.err});
        cmp("b_rsp_cycle", cyc, e.cyc);
        cmp("b_rdata", rdata_b, exp_rd_b);
        cmp("b_bus_idle", {28'd0, pen_b, psel_b}, 32'd0);
      end
    end else if (err_b) begin
      nerr++;
      $display("FAIL b_err_without_valid: got 1 expected 0");
    end
  end

  // Drive one command; returns #1 after the accepting edge.
  task automatic issue(input bit b, input logic rd,
                       input logic [31:0] addr,
                       input logic [31:0] wd, input bit push,
                       input logic eerr, input logic [31:0] edata,
                       input int lat, input bit keep,
                       output int acc);
    int   n;
    exp_t e;
    @(negedge pclk);
    read_write = rd;
    wr_addr    = rd ? 32'hC000_0FF0 : addr;
    rd_addr    = rd ? addr : 32'hC000_0FF0;
    wr_data    = wd;
    if (b) tr_b = 1'b1;
    else   tr_a = 1'b1;
    n = 0;
    while (!(b ? rdy_b : rdy_a) && n < 50) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 50) begin
      nvec++;
      nerr++;
      $display("FAIL accept_wait: got no cmd_ready expected within 50");
    end
    acc = cyc;
    if (push) begin
      e = '{eerr, rd, edata, cyc + lat};
      if (b) qb.push_back(e);
      else   qa.push_back(e);
    end
    @(posedge pclk);
    #1;
    if (!keep) begin
      tr_a = 1'b0;
      tr_b = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 60) begin
      @(negedge pclk);
      n++;
    end
    nvec++;
    if (n >= 60) begin
      nerr++;
      $display("FAIL drain: got %0d pending expected 0",
               qa.size() + qb.size());
    end
    @(negedge pclk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2;
    presetn = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    cmp("rst_psel", {30'd0, psel_a}, 32'd0);
    cmp("rst_penable", {31'd0, pen_a}, 32'd0);
    cmp("rst_rsp_valid", {31'd0, vld_a}, 32'd0);
    cmp("rst_cmd_ready", {30'd0, rdy_a, rdy_b}, 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    #1;
    cmp("rel_cmd_ready", {30'd0, rdy_a, rdy_b}, 32'd3);

    // Zero-wait write to slave 0.
    issue(0, 0, 32'h0000_0010, 32'hA5A5_5A5A, 1, 0, 0, 3, 0, a1);
    cmp("wr_setup_psel", {30'd0, psel_a}, 32'd1);
    cmp("wr_setup_pen", {31'd0, pen_a}, 32'd0);
    cmp("wr_setup_pwrite", {31'd0, pwr_a}, 32'd1);
    cmp("wr_setup_paddr", paddr_a, 32'h0000_0010);
    cmp("wr_setup_pwdata", pwdata_a, 32'hA5A5_5A5A);
    @(posedge pclk);
    #1;
    cmp("wr_access_psel", {30'd0, psel_a}, 32'd1);
    cmp("wr_access_pen", {31'd0, pen_a}, 32'd1);
    drain();

    // Read slave 1 with two wait states.
    cfg_wait = 2;
    issue(0, 1, 32'h8000_0004, 0, 1, 0, 32'h1234_5678, 5, 0, a1);
    cmp("rd_setup_psel", {30'd0, psel_a}, 32'd2);
    cmp("rd_setup_paddr", paddr_a, 32'h8000_0004);
    cmp("rd_setup_pwrite", {31'd0, pwr_a}, 32'd0);
    drain();
    cfg_wait = 0;

    // Timeout on a write; read data must hold.
    cfg_hang = 1'b1;
    issue(0, 0, 32'h8000_0008, 32'h0F0F_0F0F, 1, 1, 0, 6, 0, a1);
    drain();
    cfg_hang = 1'b0;

    // Slave error on a read zeroes the data.
    cfg_err = 1'b1;
    issue(0, 1, 32'h0000_0020, 0, 1, 1, 32'h0, 3, 0, a1);
    drain();
    cfg_err = 1'b0;

    // Back-to-back with transfer held high.
    issue(0, 0, 32'h0000_0004, 32'h3C3C_3C3C, 1, 0, 0, 3, 1, a1);
    issue(0, 1, 32'h8000_0000, 0, 1, 0, 32'h1234_5678, 3, 0, a2);
    cmp("b2b_accept_gap", a2 - a1, 32'd3);
    drain();

    // Decode miss on the three-slave instance.
    issue(1, 1, 32'hC000_0000, 0, 1, 1, 32'h0, 2, 0, a1);
    cmp("derr_psel", {29'd0, psel_b}, 32'd0);
    cmp("derr_pen", {31'd0, pen_b}, 32'd0);
    drain();

    // Slave 2 read, long wait, no timeout configured.
    cfg_wait = 6;
    issue(1, 1, 32'h8000_0000, 0, 1, 0, 32'h55AA_33CC, 9, 0, a1);
    cmp("s2_setup_psel", {29'd0, psel_b}, 32'd4);
    drain();
    cfg_wait = 0;

    // Reset during ACCESS abandons the transfer.
    cfg_hang = 1'b1;
    issue(0, 1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, a1);
    @(posedge pclk);
    #1;
    cmp("abort_in_access", {31'd0, pen_a}, 32'd1);
    @(negedge pclk);
    presetn = 1'b0;
    @(posedge pclk);
    #1;
    cmp("abort_psel", {30'd0, psel_a}, 32'd0);
    cmp("abort_pen", {31'd0, pen_a}, 32'd0);
    cmp("abort_rsp_valid", {31'd0, vld_a}, 32'd0);
    cmp("abort_rdata", rdata_a, 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    cfg_hang = 1'b0;
    #1;
    cmp("abort_cmd_ready", {31'd0, rdy_a}, 32'd1);
    repeat (8) @(negedge pclk);
    cmp("pending_a", qa.size(), 32'd0);
    cmp("pending_b", qb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
